// File: rtl/vga_timing_driver.sv
// VGA raster generator and pixel driver. It produces colour, blank, sync,
// HSync and VSync. Pixels come from a ready/valid stream or from built-in
// test patterns, and the pattern/stream choice is latched only at frame
// boundaries. Every video output is registered with one cycle of latency.
// The grid pattern reads counter bits [4:0], so CNT_W must be at least 5.
module vga_timing_driver #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COLOR_W   = 8,
  parameter int CNT_W     = 12
) (
  input  logic                   ul1Clock,
  input  logic                   ul1Reset_n,
  input  logic                   ul1Enable,
  input  logic [1:0]             ul2Mode,
  input  logic                   ul1ClearStatus,
  input  logic [3*COLOR_W-1:0]   ulPixData,
  input  logic                   ul1PixValid,
  output logic                   ul1PixReady,
  output logic [COLOR_W-1:0]     ulRed,
  output logic [COLOR_W-1:0]     ulGreen,
  output logic [COLOR_W-1:0]     ulBlue,
  output logic                   ul1Blank_n,
  output logic                   ul1Sync_n,
  output logic                   ul1HSync,
  output logic                   ul1VSync,
  output logic                   ul1FrameStart,
  output logic                   ul1Underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYN_S  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYN_E  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYN_S  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYN_E  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

  // Width of one colour bar; narrow rasters still get eight 1-pixel bars.
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? (H_ACTIVE / 8) : 1;

  localparam logic [COLOR_W-1:0] C_MAX  = '1;
  localparam logic [COLOR_W-1:0] C_GREY = COLOR_W'(1) << (COLOR_W - 1);

  // Raster position, latched source mode and registered output bundle.
  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic [COLOR_W-1:0] red_q, red_d;
  logic [COLOR_W-1:0] green_q, green_d;
  logic [COLOR_W-1:0] blue_q, blue_d;
  logic               blank_n_q, blank_n_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               frame_start_q, frame_start_d;
  logic               underflow_q, underflow_d;

  logic               active;
  logic               frame_end;
  logic               pix_ready;
  logic               grid_line;
  logic [6:0]         bar_ge;
  logic [2:0]         bar_idx;
  logic [2:0]         bar_c;
  logic [COLOR_W-1:0] pix_r, pix_g, pix_b;

  assign active    = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
  assign frame_end = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
  assign pix_ready = ul1Enable && (mode_q == 2'd0) && active;
  assign grid_line = (h_cnt_q[4:0] == 5'd0) || (v_cnt_q[4:0] == 5'd0);

  // One comparator per bar boundary; counting how many boundaries hCnt has
  // passed gives hCnt/BAR_W already clamped to 7 without a divider.
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar
      assign bar_ge[gi-1] = (h_cnt_q >= CNT_W'(gi * BAR_W));
    end
  endgenerate

  // Bar index from the boundary comparators, inverted so bar 0 is white.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 0; k < 7; k++) begin
      bar_idx = bar_idx + {2'b00, bar_ge[k]};
    end
    bar_c = 3'd7 - bar_idx;
  end

  // Pixel source mux; anything outside the active region is black.
  always_comb begin
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    if (active) begin
      case (mode_q)
        2'd0: begin
          // A missing stream word shows as black rather than stalling.
          if (ul1PixValid) begin
            {pix_r, pix_g, pix_b} = ulPixData;
          end
        end
        2'd1: begin
          pix_r = bar_c[2] ? C_MAX : '0;
          pix_g = bar_c[1] ? C_MAX : '0;
          pix_b = bar_c[0] ? C_MAX : '0;
        end
        2'd2: begin
          if (grid_line) begin
            pix_r = C_MAX;
            pix_g = C_MAX;
            pix_b = C_MAX;
          end
        end
        default: begin
          pix_r = C_GREY;
          pix_g = C_GREY;
          pix_b = C_GREY;
        end
      endcase
    end
  end

  // Next raster position, mode latch, output bundle and underflow flag.
  always_comb begin
    h_cnt_d       = '0;
    v_cnt_d       = '0;
    mode_d        = ul2Mode;
    red_d         = '0;
    green_d       = '0;
    blue_d        = '0;
    blank_n_d     = 1'b0;
    hsync_d       = ~HSYNC_POL;
    vsync_d       = ~VSYNC_POL;
    frame_start_d = 1'b0;

    if (ul1Enable) begin
      if (h_cnt_q == H_LAST) begin
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
      end
      // A mode change requested mid-frame waits for the last pixel.
      mode_d        = frame_end ? ul2Mode : mode_q;
      red_d         = pix_r;
      green_d       = pix_g;
      blue_d        = pix_b;
      blank_n_d     = active;
      hsync_d       = ((h_cnt_q >= H_SYN_S) && (h_cnt_q < H_SYN_E)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = ((v_cnt_q >= V_SYN_S) && (v_cnt_q < V_SYN_E)) ? VSYNC_POL : ~VSYNC_POL;
      frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Setting the flag takes priority over a simultaneous clear.
    if (pix_ready && !ul1PixValid) begin
      underflow_d = 1'b1;
    end else if (ul1ClearStatus) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // State register with asynchronous reset to the idle/blank bundle.
  always_ff @(posedge ul1Clock or negedge ul1Reset_n) begin
    if (!ul1Reset_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      mode_q        <= 2'd0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      blank_n_q     <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      mode_q        <= mode_d;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      blank_n_q     <= blank_n_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign ul1PixReady   = pix_ready;
  assign ulRed         = red_q;
  assign ulGreen       = green_q;
  assign ulBlue        = blue_q;
  assign ul1Blank_n    = blank_n_q;
  assign ul1Sync_n     = 1'b1;
  assign ul1HSync      = hsync_q;
  assign ul1VSync      = vsync_q;
  assign ul1FrameStart = frame_start_q;
  assign ul1Underflow  = underflow_q;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Bench for vga_timing_driver on a small 12x7 raster (8x4 visible, sync
// active high). Stimulus pushes the expected output bundle for each clock
// into a queue; a monitor pops one entry per clock and compares.
module tb_vga_timing_driver;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  md;
  logic        clr;
  logic [23:0] dat;
  logic        vld;
  logic        rdy;
  logic [7:0]  red, green, blue;
  logic        blank_n, sync_n, hsync, vsync, fstart, uflow;

  vga_timing_driver #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
    .COLOR_W(8), .CNT_W(12)
  ) dut (
    .ul1Clock(clk),
    .ul1Reset_n(rst_n),
    .ul1Enable(en),
    .ul2Mode(md),
    .ul1ClearStatus(clr),
    .ulPixData(dat),
    .ul1PixValid(vld),
    .ul1PixReady(rdy),
    .ulRed(red),
    .ulGreen(green),
    .ulBlue(blue),
    .ul1Blank_n(blank_n),
    .ul1Sync_n(sync_n),
    .ul1HSync(hsync),
    .ul1VSync(vsync),
    .ul1FrameStart(fstart),
    .ul1Underflow(uflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          h;
    int          v;
    logic [23:0] rgb;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        fs;
    logic        uf;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];

  int errors = 0;
  int checks = 0;
  int rdy_seen = 0;

  // Hand-written bar colours for an 8-pixel line: one pixel per bar.
  logic [23:0] bars_tab [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'hFF00FF, 24'hFF0000,
                                  24'h00FFFF, 24'h00FF00, 24'h0000FF, 24'h000000};

  // Bench-side view of where the raster should be and what it latched.
  int          h_pos = 0;
  int          v_pos = 0;
  logic [1:0]  mode_m = 2'd0;
  logic        uf_m = 1'b0;
  logic [23:0] dat_ctr = 24'h100000;

  task automatic step(input logic s_en, input logic [1:0] s_md, input logic s_vld, input logic s_clr);
    exp_t e;
    logic act;
    @(negedge clk);
    en  = s_en;
    md  = s_md;
    vld = s_vld;
    clr = s_clr;
    dat = dat_ctr;
    act = (h_pos < 8) && (v_pos < 4);
    e.h = h_pos;
    e.v = v_pos;
    e.rgb = 24'h0;
    e.blank = 1'b0;
    e.hs = 1'b0;
    e.vs = 1'b0;
    e.fs = 1'b0;
    e.rdy = s_en && (mode_m == 2'd0) && act;
    if (s_en) begin
      e.blank = act;
      e.hs = (h_pos == 9) || (h_pos == 10);
      e.vs = (v_pos == 5);
      e.fs = (h_pos == 0) && (v_pos == 0);
      if (act) begin
        case (mode_m)
          2'd0: e.rgb = s_vld ? dat_ctr : 24'h0;
          2'd1: e.rgb = bars_tab[h_pos];
          2'd2: e.rgb = (h_pos == 0 || v_pos == 0) ? 24'hFFFFFF : 24'h0;
          default: e.rgb = 24'h808080;
        endcase
      end
    end
    if (e.rdy && !s_vld) uf_m = 1'b1;
    else if (s_clr) uf_m = 1'b0;
    e.uf = uf_m;
    exp_q.push_back(e);
    if (!s_en || (h_pos == 11 && v_pos == 6)) mode_m = s_md;
    if (!s_en) begin
      h_pos = 0;
      v_pos = 0;
    end else if (h_pos == 11) begin
      h_pos = 0;
      v_pos = (v_pos == 6) ? 0 : v_pos + 1;
    end else begin
      h_pos = h_pos + 1;
    end
    dat_ctr = dat_ctr + 24'h030507;
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, got, want);
    end
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if ({red, green, blue} !== 24'h0) begin
      errors++;
      $display("FAIL %s colour: got %h want 000000", tag, {red, green, blue});
    end
    check_bit({tag, " blank_n"}, blank_n, 1'b0);
    check_bit({tag, " sync_n"}, sync_n, 1'b1);
    check_bit({tag, " hsync"}, hsync, 1'b0);
    check_bit({tag, " vsync"}, vsync, 1'b0);
    check_bit({tag, " frame_start"}, fstart, 1'b0);
    check_bit({tag, " underflow"}, uflow, 1'b0);
  endtask

  // Monitor: snapshot Ready mid-cycle, then compare the registered bundle
  // produced by the following rising edge against the queued expectation.
  initial begin
    logic rdy_snap;
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      rdy_snap = rdy;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({red, green, blue, blank_n, sync_n, hsync, vsync, fstart, uflow} !==
            {e.rgb, e.blank, 1'b1, e.hs, e.vs, e.fs, e.uf}) begin
          errors++;
          $display("FAIL out h=%0d v=%0d: got rgb=%h bl=%b sy=%b hs=%b vs=%b fs=%b uf=%b want rgb=%h bl=%b sy=1 hs=%b vs=%b fs=%b uf=%b",
                   e.h, e.v, {red, green, blue}, blank_n, sync_n, hsync, vsync, fstart, uflow,
                   e.rgb, e.blank, e.hs, e.vs, e.fs, e.uf);
        end
        checks++;
        if (rdy_snap !== e.rdy) begin
          errors++;
          $display("FAIL ready h=%0d v=%0d: got %b want %b", e.h, e.v, rdy_snap, e.rdy);
        end
        if (rdy_snap === 1'b1) rdy_seen++;
        if (e.rdy) begin
          $display("pix h=%0d v=%0d rgb=%h blank_n=%b uf=%b", e.h, e.v, {red, green, blue}, blank_n, uflow);
        end
      end
    end
  end

  initial begin
    int v;
    int h;
    rst_n = 1'b0;
    en    = 1'b0;
    md    = 2'd0;
    clr   = 1'b0;
    dat   = 24'h0;
    vld   = 1'b0;
    #2;
    check_reset("reset");
    #1;
    rst_n = 1'b1;

    // Idle with Enable low.
    repeat (3) step(1'b0, 2'd0, 1'b0, 1'b0);

    // Frame 1: clean stream, every Ready accepted.
    for (int i = 0; i < 84; i++) step(1'b1, 2'd0, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    checks++;
    if (rdy_seen != 32) begin
      errors++;
      $display("FAIL ready_per_frame: got %0d want 32", rdy_seen);
    end

    // Frame 2: three missed words on line 1, set+clear collision on line 2,
    // clear on line 3, and a request for bars from line 2 onward.
    for (int i = 0; i < 84; i++) begin
      v = i / 12;
      h = i % 12;
      step(1'b1, (v >= 2) ? 2'd1 : 2'd0,
           !((v == 1 && h >= 2 && h <= 4) || (v == 2 && h == 0)),
           (v == 2 && h == 0) || (v == 3 && h == 9));
    end

    // Frame 3: bars; grid requested half-way through.
    for (int i = 0; i < 84; i++) step(1'b1, (i < 42) ? 2'd1 : 2'd2, 1'b1, 1'b0);
    // Frame 4: grid; grey requested.
    for (int i = 0; i < 84; i++) step(1'b1, 2'd3, 1'b1, 1'b0);
    // Frame 5: grey, aborted part way by Enable low for 10 clocks.
    for (int i = 0; i < 29; i++) step(1'b1, 2'd3, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 2'd0, 1'b1, 1'b0);
    // Restart in stream mode with no data: black pixels and underflow.
    for (int i = 0; i < 30; i++) step(1'b1, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async_reset");

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_driver.md
Name: vga_timing_driver

Overview:
Parametrised VGA raster generator and pixel driver that produces the full VGA out bundle: colour, blank, sync, HSync and VSync. Resolution, porch/sync timing, sync polarity and colour depth are all parameters. Pixels come either from an upstream ready/valid stream or from built-in test patterns, with the mode switched only at frame boundaries. Sits between the frame-buffer reader and the DAC/connector pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, asserted level of ul1HSync
VSYNC_POL, 0, asserted level of ul1VSync
COLOR_W, 8, bits per colour channel
CNT_W, 12, counter width; must satisfy 2^CNT_W > max(H_TOTAL, V_TOTAL)

Ports:
ul1Clock  in  1  pixel clock; all logic on rising edge
ul1Reset_n  in  1  asynchronous active-low reset
ul1Enable  in  1  run raster; low holds raster idle at (0,0)
ul2Mode  in  2  0 stream, 1 colour bars, 2 grid, 3 flat grey
ul1ClearStatus  in  1  clears ul1Underflow
ulPixData  in  3*COLOR_W  stream pixel {R,G,B}
ul1PixValid  in  1  stream pixel valid
ul1PixReady  out  1  driver consumes a pixel this cycle
ulRed/ulGreen/ulBlue  out  COLOR_W each  colour out
ul1Blank_n  out  1  high in active region
ul1Sync_n  out  1  constant 1 (no sync-on-green)
ul1HSync  out  1  horizontal sync
ul1VSync  out  1  vertical sync
ul1FrameStart  out  1  one-cycle pulse aligned with the first output pixel (0,0)
ul1Underflow  out  1  sticky: stream missed a pixel

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. hCnt counts 0..H_TOTAL-1, then wraps to 0 and increments vCnt; vCnt wraps after V_TOTAL-1.
- Counters advance on every edge with ul1Enable=1. When ul1Enable=0 they are forced to (0,0), so dropping Enable mid-frame aborts the frame.
- Active region: hCnt<H_ACTIVE && vCnt<V_ACTIVE.
- HSync is asserted when H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC. VSync is asserted for whole lines with V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC. Asserted = *_POL; deasserted = ~*_POL.
- All video outputs are registered with 1-cycle latency. Outputs after edge e reflect the counter value sampled at e.
- If Enable was sampled 0 at edge e, outputs load idle values: colour 0, Blank_n 0, syncs deasserted, FrameStart 0.
- Reset values: colour 0, Blank_n 0, Sync_n 1, HSync=~HSYNC_POL, VSync=~VSYNC_POL, FrameStart 0, Underflow 0, counters (0,0), modeReg 0.
- Colour is forced to 0 whenever the output is blanked.
- Mode latch:
  - modeReg loads ul2Mode on every edge with Enable=0.
  - With Enable=1, it loads only on the edge where hCnt=H_TOTAL-1 && vCnt=V_TOTAL-1.
  - A mid-frame change therefore takes effect at the next frame.
- Stream handshake:
  - ul1PixReady = Enable && modeReg==0 && active(hCnt,vCnt), combinational from registered state.
  - Ready && Valid at edge e: the pixel appears on the outputs after e.
  - Ready && !Valid: output black for that pixel and set ul1Underflow. The driver never stalls the raster.
  - Valid without Ready is ignored (not consumed).
- ul1Underflow clears on ClearStatus. If set and clear occur on the same edge, set wins.
- Test patterns (active region only; MAX = all ones):
  - Bars: i = hCnt/(H_ACTIVE/8) clamped to 7, c = 7-i; R=MAX if c[2], G=MAX if c[1], B=MAX if c[0]. Order: white, yellow, magenta, red, cyan, green, blue, black.
  - Grid: white when hCnt[4:0]==0 or vCnt[4:0]==0, else black.
  - Grey: each channel = MSB-only (1<<(COLOR_W-1)).
- Reset asserted mid-frame: all outputs go to reset values immediately, asynchronously.

Test Plan:
- Defaults, Enable=1 continuously -> HSync falling-edge period 800 clocks, low for 96. VSync low for 1600 clocks, period 420000. FrameStart exactly once per 420000.
- Stream mode, Valid=1, data=incrementing count -> 640 Ready cycles/line, 307200/frame. Each accepted word appears 1 cycle later with Blank_n=1. Underflow stays 0.
- Valid dropped for 3 Ready cycles on line 5 -> 3 black pixels, Underflow=1 until ClearStatus pulse. Set+clear on the same edge keeps 1.
- Mode 0->1 written at line 100 -> current frame remains stream. Next frame: x=0 outputs (MAX,MAX,MAX), x=80 outputs (MAX,MAX,0), x=560 outputs (0,0,0). Ready stays 0 throughout.
- Params H 8/1/2/1, V 4/1/1/1, POL=1 -> line of 12 clocks, HSync high at hCnt 9-10. Frame of 7 lines, VSync high on line 5.
- Enable low at line 200, then high after 10 clocks -> idle outputs 1 cycle after Enable drops. FrameStart pulses 1 cycle after Enable is sampled high. ul1Reset_n low mid-line -> outputs go to reset values without waiting for a clock edge.
